// File: rtl/rdy_done_host.sv
// rdy_done_host
//   Initiator side of the four-phase start/done handshake. A request on `go`
//   latches `operand`, raises `start` until the worker answers with `done`,
//   captures `result`, waits for `done` to return to zero, and then waits for
//   `go` to fall so that each high level of `go` issues exactly one job.
//   A saturating timer bounds the wait in REQ and RELEASE; expiry aborts the
//   job and sets a sticky `timeout_err`.
//
// Ports
//   CLOCK_50     in   clock (50 MHz)
//   rst_n        in   asynchronous active-low reset
//   go           in   level request (debounced, synchronous)
//   operand      in   job input, sampled when the request is accepted
//   done         in   worker completion
//   result       in   worker output, valid while done=1
//   start        out  request to the worker
//   op_data      out  latched operand
//   busy         out  high whenever the state is not IDLE
//   result_out   out  last captured result
//   result_valid out  one-cycle pulse on capture
//   job_count    out  completed jobs, 12-bit wrapping
//   timeout_err  out  sticky abort flag, cleared on the next accepted request
//   state        out  state code (IDLE=0 REQ=1 RELEASE=2 HOLD=3 ABORT=4)
module rdy_done_host #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 50_000_000,
    parameter int TO_W    = 26
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              go,
    input  logic [DATA_W-1:0] operand,
    input  logic              done,
    input  logic [DATA_W-1:0] result,
    output logic              start,
    output logic [DATA_W-1:0] op_data,
    output logic              busy,
    output logic [DATA_W-1:0] result_out,
    output logic              result_valid,
    output logic [11:0]       job_count,
    output logic              timeout_err,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        REQ     = 4'd1,
        RELEASE = 4'd2,
        HOLD    = 4'd3,
        ABORT   = 4'd4
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    state_e              state_q, state_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   op_data_q, op_data_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   result_out_q, result_out_d;
    logic                result_valid_q, result_valid_d;
    logic [11:0]         job_count_q, job_count_d;
    logic                timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]     timer_q, timer_d;
    logic [TO_W-1:0]     timer_inc;

    // Saturating increment: the timer must never wrap back under TO_LAST.
    assign timer_inc = (timer_q == TO_MAX) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        op_data_d      = op_data_q;
        result_out_d   = result_out_q;
        result_valid_d = 1'b0;
        job_count_d    = job_count_q;
        timeout_err_d  = timeout_err_q;
        timer_d        = timer_q;

        case (state_q)
            IDLE: begin
                start_d = 1'b0;
                // A worker still holding done has not finished the previous
                // return-to-zero phase; do not start a new job yet.
                if (go && !done) begin
                    state_d       = REQ;
                    start_d       = 1'b1;
                    op_data_d     = operand;
                    timer_d       = '0;
                    timeout_err_d = 1'b0;
                end
            end
            REQ: begin
                timer_d = timer_inc;
                // done has priority over a coincident timeout.
                if (done) begin
                    state_d        = RELEASE;
                    start_d        = 1'b0;
                    result_out_d   = result;
                    result_valid_d = 1'b1;
                    job_count_d    = job_count_q + 12'd1;
                    timer_d        = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d       = ABORT;
                    start_d       = 1'b0;
                    timeout_err_d = 1'b1;
                end
            end
            RELEASE: begin
                start_d = 1'b0;
                timer_d = timer_inc;
                if (!done) begin
                    state_d = HOLD;
                end else if (timer_q == TO_LAST) begin
                    state_d       = ABORT;
                    timeout_err_d = 1'b1;
                end
            end
            HOLD: begin
                start_d = 1'b0;
                if (!go) state_d = IDLE;
            end
            ABORT: begin
                start_d = 1'b0;
                if (!done && !go) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            start_q        <= 1'b0;
            op_data_q      <= '0;
            busy_q         <= 1'b0;
            result_out_q   <= '0;
            result_valid_q <= 1'b0;
            job_count_q    <= '0;
            timeout_err_q  <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            op_data_q      <= op_data_d;
            busy_q         <= busy_d;
            result_out_q   <= result_out_d;
            result_valid_q <= result_valid_d;
            job_count_q    <= job_count_d;
            timeout_err_q  <= timeout_err_d;
            timer_q        <= timer_d;
        end
    end

    assign start        = start_q;
    assign op_data      = op_data_q;
    assign busy         = busy_q;
    assign result_out   = result_out_q;
    assign result_valid = result_valid_q;
    assign job_count    = job_count_q;
    assign timeout_err  = timeout_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_rdy_done_host.sv
module tb_rdy_done_host;

    localparam int DW = 16;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [DW-1:0] operand;
    logic          done;
    logic [DW-1:0] result;
    logic          start;
    logic [DW-1:0] op_data;
    logic          busy;
    logic [DW-1:0] result_out;
    logic          result_valid;
    logic [11:0]   job_count;
    logic          timeout_err;
    logic [3:0]    state;

    rdy_done_host #(.DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .go(go), .operand(operand),
        .done(done), .result(result), .start(start), .op_data(op_data),
        .busy(busy), .result_out(result_out), .result_valid(result_valid),
        .job_count(job_count), .timeout_err(timeout_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic [11:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_cnt = 0;   // completed jobs, reference count (mod 4096)

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record a job that is expected to complete: its result and the count it produces.
    task automatic expect_job(input logic [DW-1:0] res);
        exp_t e;
        model_cnt = (model_cnt + 1) % 4096;
        e.res = res;
        e.cnt = 12'(model_cnt);
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every result_valid pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_out", 32'(result_out), 32'(e.res));
                chk("job_count_on_capture", 32'(job_count), 32'(e.cnt));
            end
        end
    end

    // One complete job: accept, worker answers after lat cycles, release.
    task automatic run_job(input logic [DW-1:0] op, input logic [DW-1:0] res,
                           input int lat, input bit v);
        int hi;
        operand = op;
        go      = 1'b1;
        expect_job(res);
        tick();
        hi = start ? 1 : 0;
        if (v) begin
            chk("accept_state", 32'(state), 32'd1);
            chk("accept_op_data", 32'(op_data), 32'(op));
            chk("accept_busy", 32'(busy), 32'd1);
            chk("accept_clears_timeout_err", 32'(timeout_err), 32'd0);
        end
        go      = 1'b0;
        operand = DW'($urandom);
        repeat (lat) begin
            tick();
            if (start) hi++;
        end
        if (v) chk("op_data_stable", 32'(op_data), 32'(op));
        done   = 1'b1;
        result = res;
        tick();
        if (v) begin
            chk("start_high_cycles", 32'(hi), 32'(lat + 1));
            chk("start_low_after_done", 32'(start), 32'd0);
            chk("release_state", 32'(state), 32'd2);
        end
        done   = 1'b0;
        result = DW'($urandom);
        tick();
        if (v) begin
            chk("result_valid_one_cycle", 32'(result_valid), 32'd0);
            chk("hold_state", 32'(state), 32'd3);
        end
        tick();
        if (v) begin
            chk("back_to_idle", 32'(state), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0; go = 1'b0; operand = '0; done = 1'b0; result = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_start", 32'(start), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_op_data", 32'(op_data), 32'd0);
        chk("reset_result_out", 32'(result_out), 32'd0);
        chk("reset_job_count", 32'(job_count), 32'd0);
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);

        // Basic job from the test plan.
        run_job(16'h1234, 16'hBEEF, 5, 1'b1);
        chk("job1_count", 32'(job_count), 32'(model_cnt));

        // A few randomized jobs with varied worker latency.
        for (int i = 0; i < 6; i++)
            run_job(DW'($urandom), DW'($urandom), int'($urandom_range(0, 7)), 1'b1);

        // go held high across several worker completions: one job only.
        operand = 16'hA5A5; go = 1'b1;
        expect_job(16'h0F0F);
        tick();
        done = 1'b1; result = 16'h0F0F;
        tick();
        done = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            done = 1'b1; result = DW'($urandom);
            tick();
            chk("hold_go_state", 32'(state), 32'd3);
            chk("hold_go_start", 32'(start), 32'd0);
            done = 1'b0;
            tick();
            chk("hold_go_state2", 32'(state), 32'd3);
        end
        go = 1'b0;
        tick();
        chk("hold_go_idle", 32'(state), 32'd0);
        chk("hold_go_count", 32'(job_count), 32'(model_cnt));

        // done stuck high in IDLE blocks a new request.
        done = 1'b1; go = 1'b1;
        repeat (3) begin
            tick();
            chk("stuck_done_state", 32'(state), 32'd0);
            chk("stuck_done_start", 32'(start), 32'd0);
        end
        done = 1'b0;
        run_job(16'h4321, 16'h1357, 2, 1'b1);

        // Worker never answers: start high exactly TO cycles, then abort.
        operand = 16'h0BAD; go = 1'b1;
        tick();
        go = 1'b0;
        cyc = 0;
        while (start === 1'b1 && cyc < 3 * TO) begin
            cyc++;
            tick();
        end
        chk("timeout_start_cycles", 32'(cyc), 32'(TO));
        chk("timeout_state", 32'(state), 32'd4);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        chk("timeout_count_unchanged", 32'(job_count), 32'(model_cnt));
        done = 1'b1;
        tick();
        chk("abort_waits_done_low", 32'(state), 32'd4);
        done = 1'b0;
        tick();
        chk("abort_to_idle", 32'(state), 32'd0);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        run_job(16'h2222, 16'h3333, 1, 1'b1);

        // done never returns to zero: RELEASE times out after TO cycles.
        operand = 16'h7777; go = 1'b1;
        expect_job(16'h8888);
        tick();
        go = 1'b0; done = 1'b1; result = 16'h8888;
        tick();
        cyc = 0;
        while (state === 4'd2 && cyc < 3 * TO) begin
            cyc++;
            tick();
        end
        chk("release_timeout_cycles", 32'(cyc), 32'(TO));
        chk("release_timeout_state", 32'(state), 32'd4);
        chk("release_timeout_err", 32'(timeout_err), 32'd1);
        done = 1'b0;
        tick();
        chk("release_abort_idle", 32'(state), 32'd0);

        // Asynchronous reset in the middle of REQ.
        operand = 16'hCAFE; go = 1'b1;
        tick();
        chk("pre_reset_start", 32'(start), 32'd1);
        go = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_start", 32'(start), 32'd0);
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_op_data", 32'(op_data), 32'd0);
        chk("async_reset_result_out", 32'(result_out), 32'd0);
        chk("async_reset_job_count", 32'(job_count), 32'd0);
        chk("async_reset_timeout_err", 32'(timeout_err), 32'd0);
        model_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // 4097 jobs from zero: the counter wraps to 1.
        for (int i = 0; i < 4097; i++)
            run_job(DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
        chk("wrap_job_count", 32'(job_count), 32'd1);

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rdy_done_host.md
# rdy_done_host

Initiator side of the team's four-phase start/done handshake: on a user request it latches an operand, raises `start` to a worker, waits for `done`, captures the worker's result, and completes the return-to-zero phase before accepting the next request. It sits between a debounced KEY input and any worker block that uses the start/done protocol. It also exposes a job counter, a timeout flag and its state code for HEX display on the DE-series board.

## Interface
- `DATA_W`, 16: operand and result width.
- `TIMEOUT`, 50_000_000: maximum cycles spent waiting in REQ or RELEASE (1 s at 50 MHz).
- `TO_W`, 26: timer width. Must satisfy 2^TO_W > TIMEOUT.
- `CLOCK_50`  in  1  sole clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  level request, already debounced and synchronous. One job is issued per high level.
- `operand`  in  DATA_W  job input. Sampled on the cycle `go` is accepted.
- `done`  in  1  worker completion. Synchronous to `CLOCK_50`.
- `result`  in  DATA_W  worker output. Valid while `done`=1.
- `start`  out  1  request to the worker.
- `op_data`  out  DATA_W  latched operand. Stable while `start`=1.
- `busy`  out  1  high whenever state ≠ IDLE.
- `result_out`  out  DATA_W  last captured result.
- `result_valid`  out  1  one-cycle pulse when a result is captured.
- `job_count`  out  12  number of completed jobs. Wraps.
- `timeout_err`  out  1  sticky; set on abort.
- `state`  out  4  current state code.

## Operation
- States and codes: IDLE=0, REQ=1, RELEASE=2, HOLD=3, ABORT=4. Codes 5–15 are unreachable; if entered, go to IDLE on the next cycle.
- IDLE
  - `start`=0, `busy`=0.
  - If `go`=1 and `done`=0: go to REQ, latch `operand` into `op_data`, clear the timer, clear `timeout_err`.
  - If `go`=1 and `done`=1 (worker has not returned to zero): stay in IDLE.
- REQ
  - `start`=1; timer increments each cycle.
  - If `done`=1: capture `result` into `result_out`, pulse `result_valid`, increment `job_count`, clear the timer, go to RELEASE.
  - Else if timer == TIMEOUT-1: set `timeout_err`, go to ABORT.
  - If both conditions hold in the same cycle, `done` wins.
- RELEASE
  - `start`=0; timer increments.
  - If `done`=0: go to HOLD.
  - Else if timer == TIMEOUT-1: set `timeout_err`, go to ABORT.
- HOLD
  - `start`=0. Wait for `go`=0, then go to IDLE.
  - This guarantees exactly one job per `go` assertion.
- ABORT
  - `start`=0. Go to IDLE when both `done`=0 and `go`=0.
  - No capture, and `job_count` is unchanged.
- Arithmetic and flag rules:
  - `job_count` is 12-bit unsigned and wraps 4095→0.
  - The timer saturates; it never wraps during a wait.
  - `timeout_err` stays set until the next IDLE→REQ transition.
- Reset (asynchronous, any state, including mid-handshake): state=IDLE, `start`=0, `op_data`=0, `result_out`=0, `result_valid`=0, `job_count`=0, `timeout_err`=0, timer=0, `busy`=0.

## Timing
- All outputs are registered.
- `start` rises one cycle after the cycle in which `go`=1 is sampled in IDLE. `op_data` is valid on that same edge.
- `done` sampled high in REQ at edge N gives:
  - `result_valid`=1, `result_out` updated, `job_count`+1 during cycle N+1;
  - `start`=0 at N+1.
- `result_valid` is high for exactly one cycle per job.
- `done` falling in RELEASE gives state=HOLD on the next cycle. If `go` is already 0, IDLE follows one cycle later.
- Minimum job with a zero-latency worker: 4 cycles from accept back to IDLE.
- Timeout: `start` is held high for exactly TIMEOUT cycles before dropping.

## Test plan
- Reset held, then released: all outputs 0, state=0. Pulse `go` with `operand`=0x1234, worker answers `done` after 5 cycles with `result`=0xBEEF. Required: `start` high for 6 cycles, `op_data`=0x1234, one `result_valid` pulse, `result_out`=0xBEEF, `job_count`=1, state sequence 0→1→2→3→0.
- Hold `go` high across three worker completions. Required: exactly one job issued, `job_count`=1, state stays 3 until `go` falls.
- Worker never asserts `done`, TIMEOUT=100. Required: `start` high for 100 cycles, then `timeout_err`=1, state=4, `job_count` unchanged. Next successful job clears `timeout_err`.
- `done` stuck high in IDLE while `go`=1. Required: `start` stays 0 and state stays 0 until `done` falls.
- Run 4097 jobs. Required: `job_count` wraps to 1.
- Assert `rst_n`=0 asynchronously while in REQ. Required: `start` drops immediately, without waiting for a clock edge, and all outputs return to reset values.
